// File: rtl/aes_kinv_if.sv
// Start/result handshake plus S-box and round-constant tables for aes_kinv.
// The master modport is the side that supplies keys and consumes schedule words.
interface aes_kinv_if #(parameter int Nk = 4);
    logic                in_valid;
    logic                in_ready;
    logic [Nk-1:0][31:0] KLast;
    logic [255:0][7:0]   SBox;
    logic [15:0][7:0]    RCon;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_word;
    logic [5:0]          out_index;
    logic                out_last;

    modport master (
        output in_valid, KLast, SBox, RCon, out_ready,
        input  in_ready, out_valid, out_word, out_index, out_last
    );
    modport slave (
        input  in_valid, KLast, SBox, RCon, out_ready,
        output in_ready, out_valid, out_word, out_index, out_last
    );
endinterface

// File: rtl/aes_kinv.sv
// Regenerates the AES forward key schedule from its last Nk words, emitting w[NW-1] down to w[0].
// state | meaning
// IDLE  | waiting for KLast, in_ready high
// RUN   | window holds w[idx-Nk+1..idx], out_word = w[idx]
module aes_kinv #(
    parameter int Nk = 4
) (
    input  logic      clock,
    input  logic      reset,
    aes_kinv_if.slave bus
);
    localparam int Nb = 4;
    localparam int Nr = Nk + 6;
    localparam int NW = Nb * (Nr + 1);
    localparam int J0 = NW - 1 - Nk;

    localparam logic [5:0] IDX_TOP   = 6'(NW - 1);
    localparam logic [2:0] JMOD_TOP  = 3'(Nk - 1);
    localparam logic [2:0] JMOD_INIT = 3'(J0 % Nk);
    localparam logic [3:0] JDIV_INIT = 4'(J0 / Nk);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [Nk-1:0][31:0] r_win;
    logic [5:0]          r_idx;
    logic [2:0]          r_jmod;
    logic [3:0]          r_jdiv;

    logic        w_load;
    logic        w_xfer;
    logic        w_step;
    logic [31:0] w_x;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub;
    logic [31:0] w_f;
    logic [31:0] w_new;

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_xfer        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_xfer = 1'b1;
                    if (r_idx == 6'd0)
                        w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_step = w_xfer && (r_idx != 6'd0);

    // f(j, w[j+Nk-1]) with j = idx-Nk; j mod Nk and j/Nk are tracked by r_jmod/r_jdiv
    assign w_x      = r_win[Nk-2];
    assign w_sub_in = (r_jmod == 3'd0) ? {w_x[23:0], w_x[31:24]} : w_x;
    assign w_sub    = {bus.SBox[w_sub_in[31:24]], bus.SBox[w_sub_in[23:16]],
                       bus.SBox[w_sub_in[15:8]],  bus.SBox[w_sub_in[7:0]]};

    always_comb begin
        w_f = w_x;
        if (r_jmod == 3'd0)
            w_f = w_sub ^ {bus.RCon[r_jdiv + 4'd1], 24'h0};
        else if (Nk == 8 && r_jmod == 3'd4)
            w_f = w_sub;
    end

    assign w_new = r_win[Nk-1] ^ w_f;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_win   <= '0;
            r_idx   <= 6'd0;
            r_jmod  <= 3'd0;
            r_jdiv  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_win  <= bus.KLast;
                r_idx  <= IDX_TOP;
                r_jmod <= JMOD_INIT;
                r_jdiv <= JDIV_INIT;
            end else if (w_step) begin
                r_win <= {r_win[Nk-2:0], w_new};
                r_idx <= r_idx - 6'd1;
                // Below idx = Nk the counters wrap; the resulting W[0] is never emitted
                if (r_jmod == 3'd0) begin
                    r_jmod <= JMOD_TOP;
                    r_jdiv <= r_jdiv - 4'd1;
                end else begin
                    r_jmod <= r_jmod - 3'd1;
                end
            end
        end
    end

    assign bus.out_word  = r_win[Nk-1];
    assign bus.out_index = r_idx;
    assign bus.out_last  = (r_state == RUN) && (r_idx == 6'd0);
endmodule

// File: tb/tb_aes_kinv.sv
// Scoreboard bench for aes_kinv: a forward key-expansion model fills the expected queue,
// per-instance monitors pop and compare each accepted word, FIPS-197 words are spot-checked.
module tb_aes_kinv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_kinv_if #(.Nk(4)) bus128 ();
    aes_kinv_if #(.Nk(6)) bus192 ();
    aes_kinv_if #(.Nk(8)) bus256 ();

    aes_kinv #(.Nk(4)) u128 (.clock(clk), .reset(rst), .bus(bus128));
    aes_kinv #(.Nk(6)) u192 (.clock(clk), .reset(rst), .bus(bus192));
    aes_kinv #(.Nk(8)) u256 (.clock(clk), .reset(rst), .bus(bus256));

    typedef struct {
        int          tag;
        logic [31:0] w;
        logic [5:0]  i;
        logic        l;
    } exp_t;

    exp_t              sbq[$];
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [255:0][7:0] sbox_t;
    logic [15:0][7:0]  rcon_t;
    logic [31:0]       ks[60];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_of(input logic [7:0] x);
        logic [7:0] b = 8'h00;
        if (x != 8'h00) begin
            b = 8'h01;
            for (int n = 0; n < 254; n++) b = gmul(b, x);
        end
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    function automatic logic [255:0] key_of(input int tag);
        case (tag)
            0:       return {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
            1:       return {64'h0, 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b};
            default: return 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        endcase
    endfunction

    // Standard forward expansion, independent of the inverse recurrence in the design
    function automatic void expand(input int nk, input logic [255:0] key);
        int nw = 4 * (nk + 7);
        logic [31:0] t;
        for (int i = 0; i < nk; i++) ks[i] = key[32*(nk-1-i) +: 32];
        for (int i = nk; i < nw; i++) begin
            t = ks[i-1];
            if (i % nk == 0)
                t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk], 24'h0};
            else if (nk == 8 && i % nk == 4)
                t = subw(t);
            ks[i] = ks[i-nk] ^ t;
        end
    endfunction

    function automatic logic [32:0] spot(input int tag, input int idx);
        case (tag)
            0: case (idx)
                43: return {1'b1, 32'hb6630ca6};
                42: return {1'b1, 32'he13f0cc8};
                41: return {1'b1, 32'hc9ee2589};
                40: return {1'b1, 32'hd014f9a8};
                39: return {1'b1, 32'h575c006e};
                0:  return {1'b1, 32'h2b7e1516};
                default: return 33'h0;
            endcase
            1: case (idx)
                51: return {1'b1, 32'h01002202};
                0:  return {1'b1, 32'h8e73b0f7};
                default: return 33'h0;
            endcase
            2: case (idx)
                59: return {1'b1, 32'h706c631e};
                58: return {1'b1, 32'h046df344};
                57: return {1'b1, 32'he6188d0b};
                56: return {1'b1, 32'hfe4890d1};
                0:  return {1'b1, 32'h603deb10};
                default: return 33'h0;
            endcase
            default: return 33'h0;
        endcase
    endfunction

    task automatic mon(input int tag, input logic [31:0] w, input logic [5:0] i, input logic l);
        exp_t e;
        logic [32:0] s;
        if (sbq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %h idx %0d from dut %0d expected none", w, i, tag);
            return;
        end
        e = sbq.pop_front();
        chk("dut_tag", 32'(tag), 32'(e.tag));
        chk("word", w, e.w);
        chk("index", {26'h0, i}, {26'h0, e.i});
        chk("last", {31'h0, l}, {31'h0, e.l});
        s = spot(tag, int'(i));
        if (s[32]) chk("fips_word", w, s[31:0]);
    endtask

    logic        stalled = 1'b0;
    logic [31:0] st_w    = '0;
    logic [5:0]  st_i    = '0;

    always @(negedge clk) begin
        if (bus128.out_valid) begin
            chk("in_ready_run", {31'h0, bus128.in_ready}, 32'h0);
            if (stalled) begin
                chk("stall_word", bus128.out_word, st_w);
                chk("stall_index", {26'h0, bus128.out_index}, {26'h0, st_i});
            end
            if (bus128.out_ready)
                mon(0, bus128.out_word, bus128.out_index, bus128.out_last);
        end
        stalled = bus128.out_valid && !bus128.out_ready;
        st_w    = bus128.out_word;
        st_i    = bus128.out_index;
    end

    always @(negedge clk)
        if (bus192.out_valid && bus192.out_ready)
            mon(1, bus192.out_word, bus192.out_index, bus192.out_last);

    always @(negedge clk)
        if (bus256.out_valid && bus256.out_ready)
            mon(2, bus256.out_word, bus256.out_index, bus256.out_last);

    task automatic push_exp(input int tag);
        int nk = (tag == 0) ? 4 : (tag == 1) ? 6 : 8;
        int nw = 4 * (nk + 7);
        expand(nk, key_of(tag));
        for (int i = nw - 1; i >= 0; i--)
            sbq.push_back('{tag: tag, w: ks[i], i: 6'(i), l: (i == 0)});
    endtask

    // Called at posedge+1; returns at posedge+1 just after the load edge
    task automatic start(input int tag, input logic hold);
        expand((tag == 0) ? 4 : (tag == 1) ? 6 : 8, key_of(tag));
        if (tag == 0) begin
            for (int k = 0; k < 4; k++) bus128.KLast[k] = ks[40+k];
            bus128.in_valid = 1'b1;
        end else if (tag == 1) begin
            for (int k = 0; k < 6; k++) bus192.KLast[k] = ks[46+k];
            bus192.in_valid = 1'b1;
        end else begin
            for (int k = 0; k < 8; k++) bus256.KLast[k] = ks[52+k];
            bus256.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus128.in_valid = hold && (tag == 0);
        bus192.in_valid = 1'b0;
        bus256.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && sbq.size() != 0; c++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_left", 32'(sbq.size()), 32'h0);
        sbq.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_of(8'(i));
        rcon_t = '0;
        rcon_t[0] = 8'h8d; rcon_t[1] = 8'h01; rcon_t[2] = 8'h02; rcon_t[3] = 8'h04;
        rcon_t[4] = 8'h08; rcon_t[5] = 8'h10; rcon_t[6] = 8'h20; rcon_t[7] = 8'h40;
        rcon_t[8] = 8'h80; rcon_t[9] = 8'h1b; rcon_t[10] = 8'h36;
        bus128.SBox = sbox_t; bus192.SBox = sbox_t; bus256.SBox = sbox_t;
        bus128.RCon = rcon_t; bus192.RCon = rcon_t; bus256.RCon = rcon_t;
        bus128.KLast = '0; bus192.KLast = '0; bus256.KLast = '0;
        bus128.in_valid = 1'b0; bus192.in_valid = 1'b0; bus256.in_valid = 1'b0;
        bus128.out_ready = 1'b1; bus192.out_ready = 1'b1; bus256.out_ready = 1'b1;

        #12;
        chk("rst_in_ready", {31'h0, bus128.in_ready}, 32'h1);
        chk("rst_out_valid", {31'h0, bus128.out_valid}, 32'h0);
        chk("rst_out_word", bus128.out_word, 32'h0);
        chk("rst_out_index", {26'h0, bus128.out_index}, 32'h0);
        chk("rst_out_last", {31'h0, bus128.out_last}, 32'h0);
        chk("rst_in_ready_256", {31'h0, bus256.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // AES-128 at full rate: exact latency and run length
        @(posedge clk);
        #1;
        push_exp(0);
        start(0, 1'b0);
        chk("first_valid", {31'h0, bus128.out_valid}, 32'h1);
        chk("first_index", {26'h0, bus128.out_index}, 32'd43);
        repeat (43) @(posedge clk);
        #1;
        chk("final_valid", {31'h0, bus128.out_valid}, 32'h1);
        chk("final_last", {31'h0, bus128.out_last}, 32'h1);
        @(posedge clk);
        #1;
        chk("idle_out_valid", {31'h0, bus128.out_valid}, 32'h0);
        chk("idle_in_ready", {31'h0, bus128.in_ready}, 32'h1);
        wait_drain(10);

        push_exp(1);
        start(1, 1'b0);
        wait_drain(80);

        push_exp(2);
        start(2, 1'b0);
        wait_drain(90);

        // Random backpressure
        push_exp(0);
        start(0, 1'b0);
        for (int c = 0; c < 600 && sbq.size() != 0; c++) begin
            bus128.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        bus128.out_ready = 1'b1;
        wait_drain(10);

        // Asynchronous reset mid-run, then a clean restart
        push_exp(0);
        start(0, 1'b0);
        for (int c = 0; c < 100 && !(bus128.out_valid && bus128.out_index == 6'd20); c++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_reset_index", {26'h0, bus128.out_index}, 32'd20);
        rst = 1'b1;
        #1;
        chk("reset_out_valid", {31'h0, bus128.out_valid}, 32'h0);
        chk("reset_in_ready", {31'h0, bus128.in_ready}, 32'h1);
        chk("reset_out_word", bus128.out_word, 32'h0);
        chk("reset_out_index", {26'h0, bus128.out_index}, 32'h0);
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abandoned_valid", {31'h0, bus128.out_valid}, 32'h0);
        push_exp(0);
        start(0, 1'b0);
        wait_drain(60);

        // in_valid held through the run and past the final transfer
        push_exp(0);
        push_exp(0);
        start(0, 1'b1);
        repeat (44) @(posedge clk);
        #1;
        chk("reenter_idle_valid", {31'h0, bus128.out_valid}, 32'h0);
        chk("reenter_idle_ready", {31'h0, bus128.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        chk("restart_valid", {31'h0, bus128.out_valid}, 32'h1);
        chk("restart_index", {26'h0, bus128.out_index}, 32'd43);
        bus128.in_valid = 1'b0;
        wait_drain(60);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/aes_kinv.md
AES_KINV -- requirements
Module: aes_kinv

Interface
REQ-001 Parameter: Nk, default 4, key length in 32-bit words; legal values 4, 6, 8.
REQ-002 Derived constants: Nb = 4; Nr = Nk + 6; NW = Nb*(Nr+1) = total schedule words (44/52/60).
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  last-key-words present on KLast.
REQ-007 in_ready  out  1  block idle and able to accept KLast.
REQ-008 KLast  in  Nk x 32  schedule tail; KLast[k] = w[NW-Nk+k].
REQ-009 SBox  in  256 x 8  forward AES S-box table.
REQ-010 RCon  in  16 x 8  round constants, indexed as in forward expansion (RCon[1] = 8'h01).
REQ-011 out_valid  out  1  out_word holds a valid schedule word.
REQ-012 out_ready  in  1  consumer accepts out_word this cycle.
REQ-013 out_word  out  32  schedule word w[out_index], MSB = first key byte.
REQ-014 out_index  out  6  index of out_word, NW-1 down to 0.
REQ-015 out_last  out  1  high with out_valid when out_index == 0.

Function
REQ-016 The block SHALL regenerate the forward key schedule in descending word order, one word per accepted transfer, using the inverse recurrence w[j] = w[j+Nk] ^ f(j, w[j+Nk-1]).
REQ-017 f(j,x): j mod Nk == 0 -> SubWord(RotWord(x)) ^ {RCon[j/Nk+1], 24'h0}; Nk == 8 and j mod Nk == 4 -> SubWord(x); otherwise x.
REQ-018 RotWord/SubWord SHALL match FIPS-197: RotWord rotates one byte left, and SubWord applies SBox to each byte.
REQ-019 State: window W[0..Nk-1] of 32-bit words, index register idx, FSM {IDLE, RUN}.
REQ-020 IDLE: in_ready = 1 and out_valid = 0; in_valid in IDLE -> load W[k] <= KLast[k], idx <= NW-1, and move to RUN on the next edge.
REQ-021 RUN: in_ready = 0, out_valid = 1, out_word = W[Nk-1], out_index = idx; in_valid ignored.
REQ-022 On out_valid && out_ready with idx != 0: W[k+1] <= W[k] for all k, W[0] <= W[Nk-1] ^ f(idx-Nk, W[Nk-2]), and idx <= idx-1.
REQ-023 On out_valid && out_ready with idx == 0: FSM -> IDLE; W is unchanged.
REQ-024 When idx < Nk, the W[0] value SHALL be computed by the same datapath, and that value is never emitted.
REQ-025 j mod Nk and j/Nk SHALL come from down-counters reloaded at start; no divider/modulo hardware.
REQ-026 out_valid && !out_ready: all outputs and state SHALL hold (AXI-style stable data).
REQ-027 Throughput: 1 word/cycle under continuous out_ready; first word is valid 1 cycle after the start handshake; a full run takes NW cycles.
REQ-028 New start SHALL be accepted only in IDLE; in_valid on the cycle after the final transfer is accepted.
REQ-029 All SBox lookups are combinational from the current W; the f path is not pipelined.

Reset
REQ-030 Reset assertion SHALL at any time force FSM = IDLE, out_valid = 0, in_ready = 1 after reset, idx = 0, W = 0, out_word = 0, out_index = 0, and out_last = 0.
REQ-031 A run in progress SHALL be abandoned on reset and SHALL produce no further words; the next start after deassertion runs normally.

Verification
REQ-032 AES-128, KLast = {d014f9a8, c9ee2589, e13f0cc8, b6630ca6}, out_ready = 1 -> outputs are b6630ca6 (idx 43), e13f0cc8, c9ee2589, d014f9a8, 575c006e (idx 39), ..., and the final word is 2b7e1516 (idx 0, out_last = 1) after 44 cycles.
REQ-033 AES-192, KLast = w[46..51] of FIPS-197 A.2 -> w[51] = 01002202 first, and the final word is 8e73b0f7 at idx 0.
REQ-034 AES-256, KLast = w[52..59] of FIPS-197 A.3 -> first words are 706c631e, 046df344, e6188d0b, fe4890d1, and the final word is 603deb10 at idx 0.
REQ-035 Random out_ready backpressure (~50%) -> the word sequence is identical to REQ-032, out_word/out_index are stable while stalled, and in_ready stays 0 throughout.
REQ-036 Reset pulse at idx 20 mid-run -> out_valid = 0 immediately (async); a restart with the REQ-032 key yields the full correct 44-word sequence.
REQ-037 in_valid held high during RUN and on the cycle after the final transfer -> no reload mid-run, and the second run starts 1 cycle after IDLE is re-entered.
